gcn_mem_responder: RTL and testbench

Memory-side responder for the GCN datapath. Stores the weight matrix, feature matrix and COO edge list, and loads them element-serially over a valid/ready load port. Answers the GCN core's `enable_read`/`read_address` row requests with a full 96-element row one cycle later, and answers `coo_address` with the addressed edge combinationally. It sits between the testbench or host loader and the GCN top, in the position a behavioural memory occupies today.

---
 rtl/gcn_mem_pkg.sv | 18 +
 rtl/gcn_load_ctrl.sv | 153 +++++++++++++++
 rtl/gcn_mem_responder.sv | 140 ++++++++++++++
 tb/tb_gcn_mem_responder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcn_mem_pkg.sv
// Shared definitions for the GCN memory responder.
//   state_t      : load controller FSM states
//   SEL_*        : load_sel region encodings (3 is illegal)
//   FEATURE_BASE : first read address of the feature rows
package gcn_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam logic [1:0] SEL_WEIGHT  = 2'd0;
    localparam logic [1:0] SEL_FEATURE = 2'd1;
    localparam logic [1:0] SEL_COO     = 2'd2;

    localparam int FEATURE_BASE = 512;

endpackage

// File: rtl/gcn_load_ctrl.sv
// Load controller for the GCN memory responder: IDLE/LOAD FSM, beat counter,
// load_start legality check, per-region loaded bitmaps and mem_ready.
// Ports:
//   clk, reset (async, active-low)
//   load_start/load_sel/load_row : region load request (sampled in IDLE)
//   load_valid                   : beat valid
//   load_ready                   : high while in LOAD
//   load_done / load_err         : one-cycle registered pulses
//   mem_ready                    : every region loaded since reset
//   wr_en/wr_sel/wr_row/wr_idx   : storage write strobe and target for the top
module gcn_load_ctrl
    import gcn_mem_pkg::*;
#(
    parameter int WEIGHT_ROWS     = 96,
    parameter int FEATURE_COLS    = 96,
    parameter int WEIGHT_COLS     = 3,
    parameter int FEATURE_ROWS    = 6,
    parameter int COO_NUM_OF_COLS = 6,
    parameter int ROW_BW          = 3,
    parameter int CNT_W           = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [1:0]        load_sel,
    input  logic [ROW_BW-1:0] load_row,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err,
    output logic              mem_ready,
    output logic              wr_en,
    output logic [1:0]        wr_sel,
    output logic [ROW_BW-1:0] wr_row,
    output logic [CNT_W-1:0]  wr_idx
);

    localparam int WC_W = $clog2(WEIGHT_COLS);
    localparam int FR_W = $clog2(FEATURE_ROWS);

    state_t state, state_next;

    logic [1:0]              region;
    logic [ROW_BW-1:0]       row;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        last_idx;
    logic                    legal;
    logic                    accept_start;
    logic                    beat;
    logic                    last_beat;

    logic [WEIGHT_COLS-1:0]  w_loaded, w_loaded_next;
    logic [FEATURE_ROWS-1:0] f_loaded, f_loaded_next;
    logic                    coo_loaded, coo_loaded_next;

    // A start is legal for COO regardless of load_row; rows must exist otherwise.
    always_comb begin
        legal = 1'b0;
        case (load_sel)
            SEL_WEIGHT:  legal = (int'(load_row) < WEIGHT_COLS);
            SEL_FEATURE: legal = (int'(load_row) < FEATURE_ROWS);
            SEL_COO:     legal = 1'b1;
            default:     legal = 1'b0;
        endcase
    end

    always_comb begin
        last_idx = CNT_W'(COO_NUM_OF_COLS - 1);
        case (region)
            SEL_WEIGHT:  last_idx = CNT_W'(WEIGHT_ROWS - 1);
            SEL_FEATURE: last_idx = CNT_W'(FEATURE_COLS - 1);
            default:     last_idx = CNT_W'(COO_NUM_OF_COLS - 1);
        endcase
    end

    assign accept_start = (state == IDLE) && load_start && legal;
    assign beat         = load_valid && (state == LOAD);
    assign last_beat    = beat && (cnt == last_idx);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_start) state_next = LOAD;
            LOAD:    if (last_beat)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        load_ready = (state == LOAD);
    end

    // A region only counts as loaded once its final beat is accepted, so an
    // aborted load never marks a partially written row.
    always_comb begin
        w_loaded_next   = w_loaded;
        f_loaded_next   = f_loaded;
        coo_loaded_next = coo_loaded;
        if (last_beat) begin
            case (region)
                SEL_WEIGHT:  w_loaded_next[row[WC_W-1:0]] = 1'b1;
                SEL_FEATURE: f_loaded_next[row[FR_W-1:0]] = 1'b1;
                default:     coo_loaded_next = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            region     <= SEL_WEIGHT;
            row        <= '0;
            cnt        <= '0;
            w_loaded   <= '0;
            f_loaded   <= '0;
            coo_loaded <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            mem_ready  <= 1'b0;
        end else begin
            load_done  <= last_beat;
            load_err   <= (state == IDLE) && load_start && !legal;
            w_loaded   <= w_loaded_next;
            f_loaded   <= f_loaded_next;
            coo_loaded <= coo_loaded_next;
            // Built from the next-state bitmaps so it rises alongside load_done.
            mem_ready  <= (&w_loaded_next) && (&f_loaded_next) && coo_loaded_next;
            if (accept_start) begin
                region <= load_sel;
                row    <= load_row;
                cnt    <= '0;
            end else if (beat) begin
                cnt <= last_beat ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    assign wr_en  = beat;
    assign wr_sel = region;
    assign wr_row = row;
    assign wr_idx = cnt;

endmodule

// File: rtl/gcn_mem_responder.sv
// Memory-side responder for the GCN datapath. Holds the weight columns,
// feature rows and COO edge list, loads them element-serially, answers row
// reads with one cycle of latency and COO lookups combinationally.
// Ports:
//   clk, reset (async, active-low)
//   load_start, load_sel, load_row, load_valid, load_data : load port
//   load_ready, load_done, load_err, mem_ready            : load status
//   enable_read, read_address -> data_out (registered row), rd_err (sticky)
//   coo_address -> coo_out ([0] source, [1] destination), combinational
module gcn_mem_responder
    import gcn_mem_pkg::*;
#(
    parameter int FEATURE_COLS    = 96,
    parameter int WEIGHT_ROWS     = 96,
    parameter int FEATURE_ROWS    = 6,
    parameter int WEIGHT_COLS     = 3,
    parameter int DATA_WIDTH      = 5,
    parameter int ADDRESS_WIDTH   = 13,
    parameter int COO_NUM_OF_COLS = 6,
    parameter int COO_BW          = $clog2(COO_NUM_OF_COLS),
    parameter int ROW_BW          = 3,
    parameter int LOAD_WIDTH      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_start,
    input  logic [1:0]               load_sel,
    input  logic [ROW_BW-1:0]        load_row,
    input  logic                     load_valid,
    input  logic [LOAD_WIDTH-1:0]    load_data,
    output logic                     load_ready,
    output logic                     load_done,
    output logic                     load_err,
    output logic                     mem_ready,
    input  logic                     enable_read,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0]    data_out [0:WEIGHT_ROWS-1],
    input  logic [COO_BW-1:0]        coo_address,
    output logic [COO_BW-1:0]        coo_out [0:1],
    output logic                     rd_err
);

    localparam int MAX_LEN = (FEATURE_COLS > COO_NUM_OF_COLS) ? FEATURE_COLS : COO_NUM_OF_COLS;
    localparam int CNT_W   = $clog2(MAX_LEN);
    localparam int WC_W    = $clog2(WEIGHT_COLS);
    localparam int FR_W    = $clog2(FEATURE_ROWS);

    logic                    wr_en;
    logic [1:0]              wr_sel;
    logic [ROW_BW-1:0]       wr_row;
    logic [CNT_W-1:0]        wr_idx;

    logic [DATA_WIDTH-1:0]   w_mem   [0:WEIGHT_COLS-1][0:WEIGHT_ROWS-1];
    logic [DATA_WIDTH-1:0]   f_mem   [0:FEATURE_ROWS-1][0:FEATURE_COLS-1];
    logic [COO_BW-1:0]       coo_src [0:COO_NUM_OF_COLS-1];
    logic [COO_BW-1:0]       coo_dst [0:COO_NUM_OF_COLS-1];

    logic                    hit_w;
    logic                    hit_f;

    // High load_data bits and the counter/row bits beyond each region's index
    // width carry no information for the storage.
    logic                    unused_bits;
    assign unused_bits = ^{load_data, wr_row, wr_idx};

    gcn_load_ctrl #(
        .WEIGHT_ROWS     (WEIGHT_ROWS),
        .FEATURE_COLS    (FEATURE_COLS),
        .WEIGHT_COLS     (WEIGHT_COLS),
        .FEATURE_ROWS    (FEATURE_ROWS),
        .COO_NUM_OF_COLS (COO_NUM_OF_COLS),
        .ROW_BW          (ROW_BW),
        .CNT_W           (CNT_W)
    ) u_load_ctrl (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_sel   (load_sel),
        .load_row   (load_row),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_done  (load_done),
        .load_err   (load_err),
        .mem_ready  (mem_ready),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_row     (wr_row),
        .wr_idx     (wr_idx)
    );

    // Storage is deliberately not reset; mem_ready tells the core when it is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (wr_sel)
                SEL_WEIGHT:  w_mem[wr_row[WC_W-1:0]][wr_idx] <= load_data[DATA_WIDTH-1:0];
                SEL_FEATURE: f_mem[wr_row[FR_W-1:0]][wr_idx] <= load_data[DATA_WIDTH-1:0];
                default: begin
                    coo_src[wr_idx[COO_BW-1:0]] <= load_data[2*COO_BW-1:COO_BW];
                    coo_dst[wr_idx[COO_BW-1:0]] <= load_data[COO_BW-1:0];
                end
            endcase
        end
    end

    assign hit_w = (int'(read_address) < WEIGHT_COLS);
    assign hit_f = (int'(read_address) >= FEATURE_BASE) &&
                   (int'(read_address) - FEATURE_BASE < FEATURE_ROWS);

    // FEATURE_BASE is a power of two above the row count, so the low address
    // bits are the feature row index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < WEIGHT_ROWS; k++) data_out[k] <= '0;
            rd_err <= 1'b0;
        end else if (enable_read) begin
            if (load_ready) begin
                rd_err <= 1'b1;
            end else if (hit_w) begin
                for (int k = 0; k < WEIGHT_ROWS; k++)
                    data_out[k] <= w_mem[read_address[WC_W-1:0]][k];
            end else if (hit_f) begin
                for (int k = 0; k < WEIGHT_ROWS; k++)
                    data_out[k] <= f_mem[read_address[FR_W-1:0]][k];
            end else begin
                for (int k = 0; k < WEIGHT_ROWS; k++) data_out[k] <= '0;
                rd_err <= 1'b1;
            end
        end
    end

    always_comb begin
        coo_out[0] = '0;
        coo_out[1] = '0;
        if (int'(coo_address) < COO_NUM_OF_COLS) begin
            coo_out[0] = coo_src[coo_address];
            coo_out[1] = coo_dst[coo_address];
        end
    end

endmodule

// File: tb/tb_gcn_mem_responder.sv
module tb_gcn_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0;
    logic [1:0]  load_sel = 2'd0;
    logic [2:0]  load_row = 3'd0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = 8'd0;
    logic        load_ready, load_done, load_err, mem_ready, rd_err;
    logic        enable_read = 1'b0;
    logic [12:0] read_address = 13'd0;
    logic [4:0]  data_out [0:95];
    logic [2:0]  coo_address = 3'd0;
    logic [2:0]  coo_out [0:1];

    int total = 0;
    int bad = 0;

    // reference model
    logic [4:0] m_w [0:2][0:95];
    logic [4:0] m_f [0:5][0:95];
    logic [2:0] m_src [0:5];
    logic [2:0] m_dst [0:5];
    bit         w_done [0:2];
    bit         f_done [0:5];
    bit         c_done;
    logic [4:0] exp_row [0:95];
    bit         exp_err;
    logic [7:0] beat_buf [0:95];

    gcn_mem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_sel     (load_sel),
        .load_row     (load_row),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .load_done    (load_done),
        .load_err     (load_err),
        .mem_ready    (mem_ready),
        .enable_read  (enable_read),
        .read_address (read_address),
        .data_out     (data_out),
        .coo_address  (coo_address),
        .coo_out      (coo_out),
        .rd_err       (rd_err)
    );

    always #5 clk = ~clk;

    function automatic int row_diff();
        int n = 0;
        for (int k = 0; k < 96; k++) if (data_out[k] !== exp_row[k]) n++;
        return n;
    endfunction

    function automatic bit model_mem_ready();
        bit r = c_done;
        for (int i = 0; i < 3; i++) r = r & w_done[i];
        for (int i = 0; i < 6; i++) r = r & f_done[i];
        return r;
    endfunction

    task automatic model_clear_ctrl();
        for (int i = 0; i < 3; i++) w_done[i] = 1'b0;
        for (int i = 0; i < 6; i++) f_done[i] = 1'b0;
        c_done = 1'b0;
        exp_err = 1'b0;
        for (int k = 0; k < 96; k++) exp_row[k] = 5'd0;
    endtask

    // Store the first n beats of beat_buf; mark region loaded when complete.
    task automatic model_commit(input int sel, input int row, input int n, input bit complete);
        for (int k = 0; k < n; k++) begin
            if (sel == 0) m_w[row][k] = beat_buf[k][4:0];
            else if (sel == 1) m_f[row][k] = beat_buf[k][4:0];
            else begin
                m_src[k] = beat_buf[k][5:3];
                m_dst[k] = beat_buf[k][2:0];
            end
        end
        if (complete) begin
            if (sel == 0) w_done[row] = 1'b1;
            else if (sel == 1) f_done[row] = 1'b1;
            else c_done = 1'b1;
        end
    endtask

    task automatic model_read(input int addr);
        if (addr < 3) begin
            for (int k = 0; k < 96; k++) exp_row[k] = m_w[addr][k];
        end else if (addr >= 512 && addr < 518) begin
            for (int k = 0; k < 96; k++) exp_row[k] = m_f[addr-512][k];
        end else begin
            for (int k = 0; k < 96; k++) exp_row[k] = 5'd0;
            exp_err = 1'b1;
        end
    endtask

    task automatic drive_load(input logic [1:0] sel, input logic [2:0] row, input int n,
                              input bit gaps, input int start_at, input int read_at,
                              output int accepted, output int dones, output int errs,
                              output bit ready_first, output bit done_ok, output bit mr_at_done);
        int cyc;
        bit ready_now;
        accepted = 0; dones = 0; errs = 0; cyc = 0;
        load_start = 1'b1; load_sel = sel; load_row = row;
        @(negedge clk);
        load_start = 1'b0;
        ready_first = load_ready;
        while (accepted < n && cyc < 4000) begin
            if (load_done) dones++;
            if (load_err) errs++;
            load_valid  = gaps ? (cyc % 2 == 0) : 1'b1;
            load_data   = beat_buf[accepted];
            load_start  = (start_at >= 0 && accepted == start_at);
            load_sel    = 2'd0;
            load_row    = 3'd0;
            enable_read = (read_at >= 0 && accepted == read_at);
            ready_now   = load_ready;
            @(negedge clk);
            if (load_valid && ready_now) accepted++;
            cyc++;
        end
        load_valid = 1'b0; load_start = 1'b0; enable_read = 1'b0;
        done_ok    = load_done && !load_ready;
        mr_at_done = mem_ready;
        if (load_done) dones++;
        if (load_err) errs++;
        @(negedge clk);
        if (load_done) dones++;
        if (load_err) errs++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_clear_ctrl();
        repeat (2) @(negedge clk);
        total++; if (row_diff() !== 0) begin bad++; $display("FAIL reset_data_out: %0d elements nonzero, want 0", row_diff()); end
        total++; if ({load_ready, load_done, load_err, mem_ready, rd_err} !== 5'b0) begin bad++;
            $display("FAIL reset_status: got %b want 00000", {load_ready, load_done, load_err, mem_ready, rd_err}); end
        coo_address = 3'd6; #1;
        total++; if (coo_out[0] !== 3'd0 || coo_out[1] !== 3'd0) begin bad++;
            $display("FAIL reset_coo_oob: got {%0d,%0d} want {0,0}", coo_out[0], coo_out[1]); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_weight_load();
        int acc, dn, er; bit rf, dok, mr;
        for (int k = 0; k < 96; k++) beat_buf[k] = {3'($urandom), 5'(k % 32)};
        drive_load(2'd0, 3'd1, 96, 1'b0, -1, -1, acc, dn, er, rf, dok, mr);
        model_commit(0, 1, 96, 1'b1);
        total++; if (acc !== 96) begin bad++; $display("FAIL w_beats: got %0d want 96", acc); end
        total++; if (dn !== 1 || !dok) begin bad++; $display("FAIL w_done: pulses=%0d at_end=%0d want 1/1", dn, dok); end
        total++; if (!rf) begin bad++; $display("FAIL w_ready_rise: got 0 want 1"); end
        total++; if (mr !== model_mem_ready()) begin bad++; $display("FAIL w_mem_ready: got %0d want %0d", mr, model_mem_ready()); end
        enable_read = 1'b1; read_address = 13'd1;
        @(negedge clk);
        enable_read = 1'b0; read_address = 13'd2;
        model_read(1);
        total++; if (row_diff() !== 0) begin bad++; $display("FAIL w_read: %0d elements differ, want 0", row_diff()); end
        total++; if (data_out[37] !== 5'd5) begin bad++; $display("FAIL w_read_k37: got %0d want 5", data_out[37]); end
        @(negedge clk);
        total++; if (row_diff() !== 0) begin bad++; $display("FAIL w_hold: %0d elements changed, want 0", row_diff()); end
        total++; if (rd_err !== exp_err) begin bad++; $display("FAIL w_rd_err: got %0d want %0d", rd_err, exp_err); end
    endtask

    task automatic test_feature_load();
        int acc, dn, er; bit rf, dok, mr;
        for (int k = 0; k < 96; k++) beat_buf[k] = {3'($urandom), 5'd7};
        drive_load(2'd1, 3'd5, 96, 1'b0, -1, -1, acc, dn, er, rf, dok, mr);
        model_commit(1, 5, 96, 1'b1);
        total++; if (acc !== 96 || dn !== 1 || !dok) begin bad++;
            $display("FAIL f_load: beats=%0d pulses=%0d want 96/1", acc, dn); end
        enable_read = 1'b1; read_address = 13'd517;
        @(negedge clk);
        enable_read = 1'b0;
        model_read(517);
        total++; if (row_diff() !== 0) begin bad++; $display("FAIL f_read517: %0d elements differ", row_diff()); end
        total++; if (data_out[95] !== 5'd7) begin bad++; $display("FAIL f_read517_last: got %0d want 7", data_out[95]); end
        total++; if (rd_err !== 1'b0) begin bad++; $display("FAIL f_rd_err: got %0d want 0", rd_err); end
    endtask

    task automatic test_gap_load();
        int acc, dn, er; bit rf, dok, mr;
        for (int k = 0; k < 96; k++) beat_buf[k] = 8'($urandom);
        read_address = 13'd0;
        drive_load(2'd1, 3'd2, 96, 1'b1, 10, 20, acc, dn, er, rf, dok, mr);
        model_commit(1, 2, 96, 1'b1);
        exp_err = 1'b1;
        total++; if (acc !== 96) begin bad++; $display("FAIL gap_beats: got %0d want 96", acc); end
        total++; if (dn !== 1 || er !== 0) begin bad++; $display("FAIL gap_pulses: done=%0d err=%0d want 1/0", dn, er); end
        total++; if (row_diff() !== 0) begin bad++; $display("FAIL gap_hold: %0d elements changed", row_diff()); end
        total++; if (rd_err !== exp_err) begin bad++; $display("FAIL gap_rd_err: got %0d want %0d", rd_err, exp_err); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL gap_idle: load_ready=%0d want 0", load_ready); end
        enable_read = 1'b1; read_address = 13'd514;
        @(negedge clk);
        enable_read = 1'b0;
        model_read(514);
        total++; if (row_diff() !== 0) begin bad++; $display("FAIL gap_read514: %0d elements differ", row_diff()); end
    endtask

    task automatic test_bad_access();
        logic [1:0] isel [0:2];
        logic [2:0] irow [0:2];
        isel[0] = 2'd3; irow[0] = 3'd0;
        isel[1] = 2'd0; irow[1] = 3'd3;
        isel[2] = 2'd1; irow[2] = 3'd6;
        // fresh reset so the sticky error starts clear
        reset = 1'b0; @(negedge clk); reset = 1'b1; @(negedge clk);
        model_clear_ctrl();
        enable_read = 1'b1; read_address = 13'd517;
        @(negedge clk);
        read_address = 13'd518;
        model_read(517);
        total++; if (rd_err !== 1'b0 || row_diff() !== 0) begin bad++;
            $display("FAIL bad_pre517: rd_err=%0d diffs=%0d want 0/0", rd_err, row_diff()); end
        @(negedge clk);
        enable_read = 1'b0;
        model_read(518);
        total++; if (row_diff() !== 0) begin bad++; $display("FAIL bad_read518: %0d elements nonzero", row_diff()); end
        total++; if (rd_err !== exp_err) begin bad++; $display("FAIL bad_rd_err: got %0d want %0d", rd_err, exp_err); end
        for (int i = 0; i < 3; i++) begin
            load_start = 1'b1; load_sel = isel[i]; load_row = irow[i];
            @(negedge clk);
            load_start = 1'b0;
            total++; if (load_err !== 1'b1 || load_ready !== 1'b0) begin bad++;
                $display("FAIL illegal_%0d: err=%0d ready=%0d want 1/0", i, load_err, load_ready); end
            @(negedge clk);
            total++; if (load_err !== 1'b0 || load_ready !== 1'b0) begin bad++;
                $display("FAIL illegal_after_%0d: err=%0d ready=%0d want 0/0", i, load_err, load_ready); end
        end
    endtask

    task automatic test_abort();
        int acc, dn, er, cyc; bit rf, dok, mr;
        for (int k = 0; k < 96; k++) beat_buf[k] = 8'($urandom);
        load_start = 1'b1; load_sel = 2'd0; load_row = 3'd0;
        @(negedge clk);
        load_start = 1'b0;
        acc = 0; cyc = 0;
        while (acc < 40 && cyc < 200) begin
            load_valid = 1'b1; load_data = beat_buf[acc];
            @(negedge clk);
            acc++; cyc++;
        end
        load_valid = 1'b0;
        reset = 1'b0; #1;
        model_commit(0, 0, 40, 1'b0);
        model_clear_ctrl();
        total++; if (load_ready !== 1'b0 || mem_ready !== 1'b0) begin bad++;
            $display("FAIL abort_ready: ready=%0d mem_ready=%0d want 0/0", load_ready, mem_ready); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (load_ready !== 1'b0 || rd_err !== 1'b0 || row_diff() !== 0) begin bad++;
            $display("FAIL abort_idle: ready=%0d rd_err=%0d diffs=%0d want 0/0/0", load_ready, rd_err, row_diff()); end
        for (int k = 0; k < 96; k++) beat_buf[k] = 8'($urandom);
        drive_load(2'd0, 3'd0, 96, 1'b0, -1, -1, acc, dn, er, rf, dok, mr);
        model_commit(0, 0, 96, 1'b1);
        total++; if (acc !== 96 || dn !== 1 || !dok || mr !== 1'b0) begin bad++;
            $display("FAIL abort_reload: beats=%0d pulses=%0d mem_ready=%0d want 96/1/0", acc, dn, mr); end
    endtask

    task automatic test_full_set();
        int acc, dn, er, a; bit rf, dok, mr;
        int early = 0;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 96; k++) beat_buf[k] = 8'($urandom);
            if (r < 2) drive_load(2'd0, 3'(r + 1), 96, 1'b0, -1, -1, acc, dn, er, rf, dok, mr);
            else       drive_load(2'd1, 3'(r - 2), 96, 1'b0, -1, -1, acc, dn, er, rf, dok, mr);
            if (r < 2) model_commit(0, r + 1, 96, 1'b1);
            else       model_commit(1, r - 2, 96, 1'b1);
            if (mr !== model_mem_ready() || acc !== 96 || dn !== 1) early++;
        end
        total++; if (early !== 0) begin bad++; $display("FAIL full_partial: %0d loads wrong (mem_ready/beats/done), want 0", early); end
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL full_before_coo: mem_ready=%0d want 0", mem_ready); end
        for (int k = 0; k < 6; k++) beat_buf[k] = {2'($urandom), 3'(k), 3'((k + 1) % 6)};
        drive_load(2'd2, 3'($urandom), 6, 1'b0, -1, -1, acc, dn, er, rf, dok, mr);
        model_commit(2, 0, 6, 1'b1);
        total++; if (acc !== 6 || dn !== 1 || !dok) begin bad++; $display("FAIL coo_load: beats=%0d pulses=%0d want 6/1", acc, dn); end
        total++; if (mr !== 1'b1 || mem_ready !== 1'b1) begin bad++;
            $display("FAIL coo_mem_ready: at_done=%0d after=%0d want 1/1", mr, mem_ready); end
        coo_address = 3'd3; #1;
        total++; if (coo_out[0] !== 3'd3 || coo_out[1] !== 3'd4) begin bad++;
            $display("FAIL coo_edge3: got {%0d,%0d} want {3,4}", coo_out[0], coo_out[1]); end
        for (int i = 0; i < 8; i++) begin
            logic [2:0] es, ed;
            coo_address = 3'(i); #1;
            es = (i < 6) ? m_src[i] : 3'd0;
            ed = (i < 6) ? m_dst[i] : 3'd0;
            total++; if (coo_out[0] !== es || coo_out[1] !== ed) begin bad++;
                $display("FAIL coo_addr%0d: got {%0d,%0d} want {%0d,%0d}", i, coo_out[0], coo_out[1], es, ed); end
        end
        // back-to-back reads, one per cycle
        @(negedge clk);
        a = 0;
        for (int i = 0; i <= 24; i++) begin
            if (i > 0) begin
                model_read(a);
                total++; if (row_diff() !== 0 || rd_err !== exp_err) begin bad++;
                    $display("FAIL b2b_read addr=%0d: diffs=%0d rd_err=%0d want 0/%0d", a, row_diff(), rd_err, exp_err); end
            end
            if (i == 24) begin
                enable_read = 1'b0;
            end else begin
                case ($urandom_range(0, 10))
                    0, 1, 2:       a = int'($urandom_range(0, 2));
                    9:             a = int'($urandom_range(3, 511));
                    10:            a = int'($urandom_range(518, 8191));
                    default:       a = 512 + int'($urandom_range(0, 5));
                endcase
                enable_read = 1'b1; read_address = 13'(a);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_weight_load();
        test_feature_load();
        test_gap_load();
        test_bad_access();
        test_abort();
        test_full_set();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
